// File: rtl/alu_exec_if.sv
// Handshake and data bundle between the operand muxes, the execute ALU and
// the writeback / branch-resolution consumer.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zf;
    logic             cf;
    logic             vf;
    logic             sf;

    // Upstream issue stage plus downstream consumer
    modport master (
        output in_valid, alu_sel, a, b, out_ready,
        input  in_ready, out_valid, result, zf, cf, vf, sf
    );

    // Execute unit
    modport slave (
        input  in_valid, alu_sel, a, b, out_ready,
        output in_ready, out_valid, result, zf, cf, vf, sf
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare, iterative
// one-bit-per-cycle shifter, registered result and flags held until taken.
//
// state | meaning
// IDLE  | no result pending, ready for a new op
// SHIFT | iterative shift in progress, input stalled
// DONE  | result/flags valid, waiting for out_ready
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    alu_exec_if.slave bus
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] SH_LL = 2'd0;
    localparam logic [1:0] SH_RL = 2'd1;
    localparam logic [1:0] SH_RA = 2'd2;

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [1:0]         state;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         shift_kind;
    logic [WIDTH-1:0]   result_q;
    logic               zf_q, cf_q, vf_q, sf_q;

    logic               accept;
    logic               is_sub;
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         sel_kind;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cf, alu_vf;
    logic [WIDTH-1:0]   acc_step;

    // Reset and flush both block acceptance so an aborted cycle can never issue.
    assign bus.in_ready  = rst & ~flush &
                           ((state == S_IDLE) | ((state == S_DONE) & bus.out_ready));
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_q;
    assign bus.zf        = zf_q;
    assign bus.cf        = cf_q;
    assign bus.vf        = vf_q;
    assign bus.sf        = sf_q;

    // Shared adder: SUB is a + ~b + 1 so cf doubles as the no-borrow flag.
    assign is_sub = (bus.alu_sel == ALU_SUB);
    assign b_eff  = is_sub ? ~bus.b : bus.b;
    assign sum    = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign shamt  = bus.b[SHAMT_W-1:0];

    // Single-cycle result and flags; shifts report a here for the shamt==0 case.
    always_comb begin
        alu_res  = bus.b;
        alu_cf   = 1'b0;
        alu_vf   = 1'b0;
        is_shift = 1'b0;
        sel_kind = SH_LL;
        case (bus.alu_sel)
            ALU_ADD, ALU_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_cf  = sum[WIDTH];
                alu_vf  = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_AND:  alu_res = bus.a & bus.b;
            ALU_OR:   alu_res = bus.a | bus.b;
            ALU_XOR:  alu_res = bus.a ^ bus.b;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            ALU_SLL: begin
                alu_res  = bus.a;
                is_shift = 1'b1;
                sel_kind = SH_LL;
            end
            ALU_SRL: begin
                alu_res  = bus.a;
                is_shift = 1'b1;
                sel_kind = SH_RL;
            end
            ALU_SRA: begin
                alu_res  = bus.a;
                is_shift = 1'b1;
                sel_kind = SH_RA;
            end
            default: alu_res = bus.b;
        endcase
    end

    // One bit of shift per cycle on the accumulator.
    always_comb begin
        acc_step = {acc[WIDTH-2:0], 1'b0};
        case (shift_kind)
            SH_RL:   acc_step = {1'b0, acc[WIDTH-1:1]};
            SH_RA:   acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: acc_step = {acc[WIDTH-2:0], 1'b0};
        endcase
    end

    // Control FSM, shifter datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            shift_kind <= SH_LL;
            result_q   <= '0;
            zf_q       <= 1'b0;
            cf_q       <= 1'b0;
            vf_q       <= 1'b0;
            sf_q       <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_SHIFT: begin
                    acc <= acc_step;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result_q <= acc_step;
                        zf_q     <= (acc_step == '0);
                        sf_q     <= acc_step[WIDTH-1];
                        cf_q     <= 1'b0;
                        vf_q     <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready && !accept)
                        state <= S_IDLE;
                end
                default: ;
            endcase
            // Acceptance only happens in IDLE or a draining DONE, so it never
            // collides with the SHIFT branch above.
            if (accept) begin
                if (is_shift && (shamt != '0)) begin
                    acc        <= bus.a;
                    cnt        <= shamt;
                    shift_kind <= sel_kind;
                    state      <= S_SHIFT;
                end else begin
                    result_q <= alu_res;
                    zf_q     <= (alu_res == '0);
                    sf_q     <= alu_res[WIDTH-1];
                    cf_q     <= alu_cf;
                    vf_q     <= alu_vf;
                    state    <= S_DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: scoreboard of expected results
// pushed at acceptance and popped when the consumer takes a result.
module tb_alu_exec_unit;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef struct packed {
        logic [31:0] res;
        logic        zf;
        logic        cf;
        logic        vf;
        logic        sf;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    alu_exec_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written from the operation definitions.
    function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        exp_t            e;
        longint          sa, sbv, r;
        longint unsigned ua, ub;
        logic [4:0]      sh;
        sa  = $signed(a);
        sbv = $signed(b);
        ua  = a;
        ub  = b;
        sh  = b[4:0];
        e   = '0;
        case (sel)
            ALU_ADD: begin
                e.res = a + b;
                e.cf  = ((ua + ub) >> 32) != 0;
                r     = sa + sbv;
                e.vf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            ALU_SUB: begin
                e.res = a - b;
                e.cf  = (a >= b);
                r     = sa - sbv;
                e.vf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            ALU_AND:  e.res = a & b;
            ALU_OR:   e.res = a | b;
            ALU_XOR:  e.res = a ^ b;
            ALU_SLT:  e.res = (sa < sbv) ? 32'd1 : 32'd0;
            ALU_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  e.res = a << sh;
            ALU_SRL:  e.res = a >> sh;
            ALU_SRA:  e.res = $signed(a) >>> sh;
            default:  e.res = b;
        endcase
        e.zf = (e.res == 32'd0);
        e.sf = e.res[31];
        return e;
    endfunction

    // Scoreboard: pop on output handshake, push on input handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst || flush) begin
            sb.delete();
        end else begin
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got result=%h with no op outstanding", bus.result);
                end else begin
                    e = sb.pop_front();
                    if ({bus.result, bus.zf, bus.cf, bus.vf, bus.sf} !== e) begin
                        n_err++;
                        $display("FAIL sb_result: got res=%h z%b c%b v%b s%b, want res=%h z%b c%b v%b s%b",
                                 bus.result, bus.zf, bus.cf, bus.vf, bus.sf,
                                 e.res, e.zf, e.cf, e.vf, e.sf);
                    end
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
                sb.push_back(model(bus.alu_sel, bus.a, bus.b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op and hold it until accepted; returns at edge+1 after acceptance.
    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output int waits);
        bit acc;
        acc          = 0;
        waits        = 0;
        bus.in_valid = 1'b1;
        bus.alu_sel  = sel;
        bus.a        = a;
        bus.b        = b;
        while (!acc && waits < 100) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) acc = 1;
            else waits++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: sel=%0d not accepted after %0d cycles, want acceptance", sel, waits);
        end
    endtask

    // Count cycles since acceptance until out_valid, bounded.
    task automatic wait_done(output int lat, output bit ready_seen);
        lat        = 1;
        ready_seen = 0;
        while (bus.out_valid !== 1'b1 && lat < 60) begin
            if (bus.in_ready !== 1'b0) ready_seen = 1;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.alu_sel   = ALU_ADD;
        bus.a         = 32'd5;
        bus.b         = 32'd7;
        step();
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b, want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.result !== 32'd0) begin
            n_err++; $display("FAIL reset_result: got %h, want 0", bus.result);
        end
        n_cmp++;
        if ({bus.zf, bus.cf, bus.vf, bus.sf} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b, want 0000", {bus.zf, bus.cf, bus.vf, bus.sf});
        end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_no_accept: got out_valid=%b in_ready=%b, want 0 1",
                              bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_arith();
        int w;
        logic [3:0]  sels[5] = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD};
        logic [31:0] as[5]   = '{32'd5, 32'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs[5]   = '{32'd7, 32'd3, 32'd1, 32'd1, 32'd1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(sels[i], as[i], bs[i], w);
            n_cmp++;
            if (bus.out_valid !== 1'b1) begin
                n_err++; $display("FAIL arith_latency[%0d]: got out_valid=%b, want 1", i, bus.out_valid);
            end
        end
        step();
    endtask

    task automatic test_shift();
        int w, lat;
        bit rdy;
        bus.out_ready = 1'b1;
        issue(ALU_SRA, 32'h8000_0000, 32'd4, w);
        wait_done(lat, rdy);
        n_cmp++;
        if (lat != 5 || rdy) begin
            n_err++; $display("FAIL sra_latency: got %0d cycles in_ready_seen=%b, want 5 and 0", lat, rdy);
        end
        issue(ALU_SLL, 32'd1, 32'h20, w);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL sll_shamt0_latency: got out_valid=%b, want 1", bus.out_valid);
        end
        issue(ALU_SLL, 32'd3, 32'd31, w);
        wait_done(lat, rdy);
        n_cmp++;
        if (lat != 32) begin
            n_err++; $display("FAIL sll31_latency: got %0d cycles, want 32", lat);
        end
        issue(ALU_SRL, 32'hF0, 32'hFFFF_FF04, w);
        wait_done(lat, rdy);
        n_cmp++;
        if (lat != 5) begin
            n_err++; $display("FAIL srl_upper_b_latency: got %0d cycles, want 5", lat);
        end
        step();
    endtask

    task automatic test_backpressure();
        int w;
        bus.out_ready = 1'b0;
        issue(ALU_ADD, 32'd1, 32'd1, w);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b1, 1'b0, 32'd2}) begin
                n_err++; $display("FAIL hold[%0d]: got v=%b rdy=%b res=%h, want 1 0 00000002",
                                  i, bus.out_valid, bus.in_ready, bus.result);
            end
            step();
        end
        bus.out_ready = 1'b1;
        issue(ALU_XOR, 32'hF0, 32'hFF, w);
        n_cmp++;
        if (w != 0 || bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL replace_no_bubble: got waits=%0d out_valid=%b, want 0 1", w, bus.out_valid);
        end
        step();
    endtask

    task automatic test_abort();
        int w;
        bit bad;
        bus.out_ready = 1'b1;
        issue(ALU_SRL, 32'hFFFF_FFFF, 32'd31, w);
        for (int i = 0; i < 8; i++) step();
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'd0) begin
            n_err++; $display("FAIL rst_mid_shift: got v=%b res=%h, want 0 00000000", bus.out_valid, bus.result);
        end
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid !== 1'b0) bad = 1;
            step();
        end
        n_cmp++;
        if (bad) begin
            n_err++; $display("FAIL rst_stale_done: got out_valid=1 after reset, want 0");
        end
        issue(ALU_SRL, 32'hFFFF_FFFF, 32'd31, w);
        step();
        step();
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.alu_sel  = ALU_ADD;
        bus.a        = 32'd2;
        bus.b        = 32'd3;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_in_ready: got %b, want 0", bus.in_ready);
        end
        step();
        flush = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_out_valid: got %b, want 0", bus.out_valid);
        end
        issue(ALU_ADD, 32'd2, 32'd3, w);
        n_cmp++;
        if (w != 0 || bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL post_flush_accept: got waits=%0d out_valid=%b, want 0 1", w, bus.out_valid);
        end
        step();
    endtask

    task automatic test_compare();
        int w;
        bus.out_ready = 1'b1;
        issue(ALU_SLT,  32'hFFFF_FFFF, 32'd1, w);
        issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, w);
        issue(4'b1111,  32'h1234_5678, 32'hDEAD_BEEF, w);
        issue(ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, w);
        issue(ALU_OR,   32'hFF00_0000, 32'h0000_00FF, w);
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  sels[6] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLTU, ALU_SUB, ALU_OR};
        logic [31:0] as[6]   = '{32'd10, 32'd1, 32'hAAAA_5555, 32'd1, 32'h7FFF_FFFF, 32'd0};
        logic [31:0] bs[6]   = '{32'd20, 32'd2, 32'h5555_5555, 32'd2, 32'hFFFF_FFFF, 32'd0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.alu_sel  = sels[i];
            bus.a        = as[i];
            bus.b        = bs[i];
            @(negedge clk);
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_ready[%0d]: got %b, want 1", i, bus.in_ready);
            end
            step();
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        int n;
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_sel   = 4'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.out_ready = 1'b1;
        test_reset();
        test_arith();
        test_shift();
        test_backpressure();
        test_abort();
        test_compare();
        test_back_to_back();
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL drain: got %0d results outstanding, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit ALU selection code produced by the ALU control decoder, together with the two operands from the operand muxes.
- Arithmetic, logic and compare ops complete in one cycle.
- Shifts run on an iterative one-bit-per-cycle shifter to save area.
- Valid/ready handshakes on both sides; the result and flags are registered and held until the downstream stage (writeback / branch resolution) accepts them.

Parameters:
WIDTH, 32, operand/result width
SHAMT_W, 5, shift-amount width taken from b[SHAMT_W-1:0]

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
flush  in  1  synchronous abort of any in-flight operation
in_valid  in  1  operands and selection valid
in_ready  out  1  unit can accept this cycle
alu_sel  in  4  ALU selection code, shared `ALU_* encoding
a  in  WIDTH  operand A (rs1 / PC)
b  in  WIDTH  operand B (rs2 / immediate)
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
zf  out  1  zero flag (result == 0)
cf  out  1  carry flag
vf  out  1  signed overflow flag
sf  out  1  sign flag (result[WIDTH-1])

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; result=0; zf, cf, vf, sf=0; out_valid=0; shift counter=0. Reset overrides flush and any handshake.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This permits back-to-back issue, with 1 result per cycle for non-shift ops.
- Acceptance occurs when in_valid & in_ready at an edge; a, b and alu_sel are sampled only at acceptance.
- Non-shift op, or shift with shamt==0, at acceptance:
  - Compute and register result and flags; state goes to DONE.
  - out_valid is seen the cycle after acceptance (latency 1).
- Shift (SLL/SRL/SRA) with shamt n>0:
  - At acceptance: acc=a, cnt=n, state goes to SHIFT.
  - Each SHIFT edge shifts acc one bit (SRA replicates the MSB) and decrements cnt.
  - On the edge where cnt==1: result=acc shifted once more, flags set, state goes to DONE.
  - Latency is n+1 cycles; maximum 32 for WIDTH=32.
- Operations:
  - ADD: a+b.
  - SUB: a+~b+1.
  - AND, OR, XOR: bitwise.
  - SLT: signed a<b gives 1, else 0.
  - SLTU: unsigned a<b gives 1, else 0.
  - PASS and any unlisted code: result=b.
- Flags:
  - ADD/SUB: cf = carry out of the WIDTH-bit adder. For SUB, cf=1 means no borrow (a>=b unsigned). vf = standard two's-complement overflow.
  - All other ops: cf=0, vf=0.
  - zf and sf always reflect the registered result.
- DONE:
  - out_valid=1; result and flags held stable while out_ready==0.
  - out_ready==1 without a new acceptance: state goes to IDLE, out_valid=0, result/flags retain their last values.
  - out_ready==1 with a simultaneous acceptance: the new op replaces the old with no bubble. A new non-shift op stays in DONE with the new data; a new shift op goes to SHIFT with out_valid=0.
- flush (rst==1): state goes to IDLE and out_valid=0 next edge, discarding any DONE or SHIFT contents. in_ready is forced 0 during the flush cycle, so no acceptance occurs.
- in_valid while in SHIFT: ignored (in_ready=0); the upstream stage must hold its data.
- Bits of b above SHAMT_W are ignored for shifts.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, result=0, all flags 0, no acceptance.
2. ADD a=5, b=7 -> one cycle later out_valid=1, result=12, zf=0, cf=0. SUB a=3, b=3 -> result=0, zf=1, cf=1, vf=0. SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, vf=1.
3. SRA a=0x80000000, b=4 -> in_ready=0 for 4 cycles, out_valid 5 cycles after acceptance, result=0xF8000000, sf=1. SLL a=1, b=0x20 (shamt 0) -> result=1 with latency 1.
4. Backpressure: ADD a=1, b=1 with out_ready=0 for 3 cycles -> result=2 held stable, in_ready=0. Then out_ready=1 with a new XOR a=0xF0, b=0xFF presented -> accepted the same cycle, next result=0x0F.
5. Interrupts mid-shift: SRL a=0xFFFFFFFF, b=31, then rst=0 at cycle 10 -> state IDLE, out_valid=0, result=0. Repeat with flush=1 -> out_valid=0, unit accepts a new op the following cycle.
6. Compares/default: SLT a=-1, b=1 -> result=1. SLTU with the same operands -> result=0. Unlisted alu_sel 4'b1111 with b=0xDEADBEEF -> result=0xDEADBEEF, cf=vf=0.
